ibex_cx_dispatch: RTL and testbench

IBEX_CX_DISPATCH -- requirements
Module: ibex_cx_dispatch

---
 rtl/ibex_cx_dispatch.sv | 235 +++++++++++++++++++++++
 tb/tb_ibex_cx_dispatch.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_cx_dispatch.sv
// ibex_cx_dispatch: routes custom-extension instructions from the core to one of
// NUM_UNITS external units and returns the unit's result, with illegal-instruction,
// timeout and flush handling. Only one operation is in flight at any time.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   req_valid_i / req_ready_o        core request handshake
//   req_instr_i, req_rs1_i, req_rs2_i instruction word and register operands
//   flush_i                          core kill of the current operation
//   cx_valid_o / cx_ready_i          one-hot per-unit issue handshake
//   cx_op_a_o, cx_op_b_o,
//   cx_func_o, cx_mode_o             shared issue payload (zero outside ISSUE)
//   cx_resp_valid_i, cx_resp_data_i,
//   cx_resp_err_i                    per-unit results, unit k at [k*XLEN +: XLEN]
//   resp_*_o                         single-cycle result to the core
//   busy_o                           high whenever not IDLE
module ibex_cx_dispatch #(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [31:0]               req_instr_i,
    input  logic [XLEN-1:0]           req_rs1_i,
    input  logic [XLEN-1:0]           req_rs2_i,
    input  logic                      flush_i,
    output logic [NUM_UNITS-1:0]      cx_valid_o,
    input  logic [NUM_UNITS-1:0]      cx_ready_i,
    output logic [XLEN-1:0]           cx_op_a_o,
    output logic [XLEN-1:0]           cx_op_b_o,
    output logic [6:0]                cx_func_o,
    output logic [1:0]                cx_mode_o,
    input  logic [NUM_UNITS-1:0]      cx_resp_valid_i,
    input  logic [NUM_UNITS*XLEN-1:0] cx_resp_data_i,
    input  logic [NUM_UNITS-1:0]      cx_resp_err_i,
    output logic                      resp_valid_o,
    output logic [XLEN-1:0]           resp_data_o,
    output logic [4:0]                resp_rd_o,
    output logic                      resp_err_o,
    output logic                      resp_illegal_o,
    output logic                      resp_timeout_o,
    output logic                      busy_o
);

    localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LAST_VAL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_VAL);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [6:0] OPC_CX_REG  = 7'h0b;
    localparam logic [6:0] OPC_CX_IMM  = 7'h2b;
    localparam logic [6:0] OPC_CX_FLEX = 7'h5b;

    localparam logic [1:0] MODE_REG  = 2'd0;
    localparam logic [1:0] MODE_IMM  = 2'd1;
    localparam logic [1:0] MODE_FLEX = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [UW-1:0]   unit_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [6:0]      func_q;
    logic [1:0]      mode_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;
    logic            err_q;
    logic            illegal_q;
    logic            timeout_q;
    logic [CW-1:0]   cnt_q;

    // Request decode
    logic [6:0]      dec_opcode;
    logic [2:0]      dec_unit;
    logic            dec_op_ok;
    logic            dec_unit_ok;
    logic [1:0]      dec_mode;
    logic [XLEN-1:0] dec_op_b;
    logic [6:0]      dec_func;

    assign dec_opcode  = req_instr_i[6:0];
    assign dec_unit    = req_instr_i[14:12];
    assign dec_unit_ok = ({1'b0, dec_unit} < 4'(NUM_UNITS));

    always_comb begin
        dec_op_ok = 1'b1;
        dec_mode  = MODE_REG;
        dec_op_b  = req_rs2_i;
        dec_func  = req_instr_i[31:25];
        case (dec_opcode)
            OPC_CX_REG:  dec_mode = MODE_REG;
            OPC_CX_IMM: begin
                dec_mode = MODE_IMM;
                dec_op_b = {{(XLEN-12){req_instr_i[31]}}, req_instr_i[31:20]};
                dec_func = 7'd0;
            end
            OPC_CX_FLEX: dec_mode = MODE_FLEX;
            default:     dec_op_ok = 1'b0;
        endcase
    end

    // rs1/rs2 index fields are not needed: operands arrive already read
    logic unused_rs_fields;
    assign unused_rs_fields = ^req_instr_i[19:15];

    // Selected-unit view of the unit-side inputs
    logic            sel_ready;
    logic            sel_resp_valid;
    logic            sel_resp_err;
    logic [XLEN-1:0] sel_resp_data;

    assign sel_ready      = cx_ready_i[unit_q];
    assign sel_resp_valid = cx_resp_valid_i[unit_q];
    assign sel_resp_err   = cx_resp_err_i[unit_q];
    assign sel_resp_data  = cx_resp_data_i[int'(unit_q) * XLEN +: XLEN];

    // Last cycle of the ISSUE+WAIT budget; a same-cycle response takes priority
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Control FSM and captured operation context
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            unit_q    <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            func_q    <= '0;
            mode_q    <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        unit_q    <= UW'(dec_unit);
                        op_a_q    <= req_rs1_i;
                        op_b_q    <= dec_op_b;
                        func_q    <= dec_func;
                        mode_q    <= dec_mode;
                        rd_q      <= req_instr_i[11:7];
                        data_q    <= '0;
                        timeout_q <= 1'b0;
                        cnt_q     <= '0;
                        if (dec_op_ok && dec_unit_ok) begin
                            err_q     <= 1'b0;
                            illegal_q <= 1'b0;
                            state_q   <= ISSUE;
                        end else begin
                            err_q     <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (sel_ready && sel_resp_valid) begin
                        data_q  <= sel_resp_data;
                        err_q   <= sel_resp_err;
                        state_q <= RESP;
                    end else if (timeout_hit) begin
                        data_q    <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        if (sel_ready) begin
                            state_q <= WAIT;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (sel_resp_valid) begin
                        data_q  <= sel_resp_data;
                        err_q   <= sel_resp_err;
                        state_q <= RESP;
                    end else if (timeout_hit) begin
                        data_q    <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state; payloads are forced to zero when idle
    logic in_issue;
    logic in_resp;

    assign in_issue = (state_q == ISSUE);
    assign in_resp  = (state_q == RESP);

    assign req_ready_o    = (state_q == IDLE) && !flush_i && !rst_i;
    assign busy_o         = (state_q != IDLE);
    assign cx_valid_o     = in_issue ? (NUM_UNITS'(1) << unit_q) : '0;
    assign cx_op_a_o      = in_issue ? op_a_q : '0;
    assign cx_op_b_o      = in_issue ? op_b_q : '0;
    assign cx_func_o      = in_issue ? func_q : '0;
    assign cx_mode_o      = in_issue ? mode_q : '0;
    assign resp_valid_o   = in_resp;
    assign resp_data_o    = in_resp ? data_q : '0;
    assign resp_rd_o      = in_resp ? rd_q : '0;
    assign resp_err_o     = in_resp & err_q;
    assign resp_illegal_o = in_resp & illegal_q;
    assign resp_timeout_o = in_resp & timeout_q;

endmodule

// File: tb/tb_ibex_cx_dispatch.sv
// Directed testbench for ibex_cx_dispatch with a response scoreboard.
module tb_ibex_cx_dispatch;

    localparam int unsigned NU = 4;
    localparam int unsigned XL = 32;
    localparam int unsigned TO = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [31:0]       req_instr_i;
    logic [XL-1:0]     req_rs1_i;
    logic [XL-1:0]     req_rs2_i;
    logic              flush_i;
    logic [NU-1:0]     cx_valid_o;
    logic [NU-1:0]     cx_ready_i;
    logic [XL-1:0]     cx_op_a_o;
    logic [XL-1:0]     cx_op_b_o;
    logic [6:0]        cx_func_o;
    logic [1:0]        cx_mode_o;
    logic [NU-1:0]     cx_resp_valid_i;
    logic [NU*XL-1:0]  cx_resp_data_i;
    logic [NU-1:0]     cx_resp_err_i;
    logic              resp_valid_o;
    logic [XL-1:0]     resp_data_o;
    logic [4:0]        resp_rd_o;
    logic              resp_err_o;
    logic              resp_illegal_o;
    logic              resp_timeout_o;
    logic              busy_o;

    always #5 clk = ~clk;

    ibex_cx_dispatch #(
        .NUM_UNITS      (NU),
        .XLEN           (XL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_instr_i     (req_instr_i),
        .req_rs1_i       (req_rs1_i),
        .req_rs2_i       (req_rs2_i),
        .flush_i         (flush_i),
        .cx_valid_o      (cx_valid_o),
        .cx_ready_i      (cx_ready_i),
        .cx_op_a_o       (cx_op_a_o),
        .cx_op_b_o       (cx_op_b_o),
        .cx_func_o       (cx_func_o),
        .cx_mode_o       (cx_mode_o),
        .cx_resp_valid_i (cx_resp_valid_i),
        .cx_resp_data_i  (cx_resp_data_i),
        .cx_resp_err_i   (cx_resp_err_i),
        .resp_valid_o    (resp_valid_o),
        .resp_data_o     (resp_data_o),
        .resp_rd_o       (resp_rd_o),
        .resp_err_o      (resp_err_o),
        .resp_illegal_o  (resp_illegal_o),
        .resp_timeout_o  (resp_timeout_o),
        .busy_o          (busy_o)
    );

    typedef struct packed {
        logic [XL-1:0] data;
        logic [4:0]    rd;
        logic          err;
        logic          ill;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [XL-1:0] d, input logic [4:0] rd,
                        input logic err, input logic ill, input logic tmo);
        exp_t e;
        e.data = d; e.rd = rd; e.err = err; e.ill = ill; e.tmo = tmo;
        sb.push_back(e);
    endtask

    // Present one request for one cycle; returns in the cycle after the accept edge
    task automatic send(input logic [31:0] instr, input logic [XL-1:0] rs1, input logic [XL-1:0] rs2);
        req_valid_i = 1'b1;
        req_instr_i = instr;
        req_rs1_i   = rs1;
        req_rs2_i   = rs2;
        #1;
        chk("req_ready_at_accept", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    // Core sees a response this cycle: pop the oldest expectation and compare
    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, ".resp_valid"}, 64'(resp_valid_o), 64'd1);
        chk({tag, ".sb_pending"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".data"},    64'(resp_data_o),    64'(e.data));
            chk({tag, ".rd"},      64'(resp_rd_o),      64'(e.rd));
            chk({tag, ".err"},     64'(resp_err_o),     64'(e.err));
            chk({tag, ".illegal"}, 64'(resp_illegal_o), 64'(e.ill));
            chk({tag, ".timeout"}, 64'(resp_timeout_o), 64'(e.tmo));
        end
    endtask

    task automatic unit_resp(input int k, input logic [XL-1:0] d, input logic err);
        cx_resp_valid_i = '0;
        cx_resp_err_i   = '0;
        cx_resp_data_i  = '0;
        cx_resp_valid_i[k] = 1'b1;
        cx_resp_err_i[k]   = err;
        cx_resp_data_i[k*XL +: XL] = d;
    endtask

    task automatic clear_unit_inputs();
        cx_ready_i      = '0;
        cx_resp_valid_i = '0;
        cx_resp_err_i   = '0;
        cx_resp_data_i  = '0;
    endtask

    function automatic logic [31:0] r_instr(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] op);
        return {f7, 10'd0, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_instr(input logic [11:0] imm, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] op);
        return {imm, 5'd0, f3, rd, op};
    endfunction

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_instr_i = '0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        flush_i     = 1'b0;
        clear_unit_inputs();
        tick();
        tick();
        rst_i = 1'b0;
        #1;

        // Reset state
        chk("rst.req_ready",  64'(req_ready_o),  64'd1);
        chk("rst.busy",       64'(busy_o),       64'd0);
        chk("rst.cx_valid",   64'(cx_valid_o),   64'd0);
        chk("rst.resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst.resp_data",  64'(resp_data_o),  64'd0);
        chk("rst.cx_op_b",    64'(cx_op_b_o),    64'd0);

        // CX_REG on unit 2 with ready and response in the issue cycle
        push(32'd12, 5'd3, 1'b0, 1'b0, 1'b0);
        send(r_instr(7'h15, 3'd2, 5'd3, 7'h0b), 32'd5, 32'd7);
        chk("t1.cx_valid",   64'(cx_valid_o),   64'h4);
        chk("t1.op_a",       64'(cx_op_a_o),    64'd5);
        chk("t1.op_b",       64'(cx_op_b_o),    64'd7);
        chk("t1.func",       64'(cx_func_o),    64'h15);
        chk("t1.mode",       64'(cx_mode_o),    64'd0);
        chk("t1.busy",       64'(busy_o),       64'd1);
        chk("t1.resp_early", 64'(resp_valid_o), 64'd0);
        cx_ready_i = 4'b0100;
        unit_resp(2, 32'd12, 1'b0);
        tick();
        clear_unit_inputs();
        check_resp("t1");
        chk("t1.cx_valid_off", 64'(cx_valid_o), 64'd0);
        chk("t1.op_a_zero",    64'(cx_op_a_o),  64'd0);
        tick();
        chk("t1.resp_once",    64'(resp_valid_o), 64'd0);
        chk("t1.data_zero",    64'(resp_data_o),  64'd0);
        chk("t1.idle",         64'(busy_o),       64'd0);

        // CX_IMM sign extension, WAIT ignores other units, error passthrough
        push(32'hABCD, 5'd5, 1'b1, 1'b0, 1'b0);
        send(i_instr(12'hFFF, 3'd0, 5'd5, 7'h2b), 32'd1, 32'h1234);
        chk("t2.cx_valid", 64'(cx_valid_o), 64'h1);
        chk("t2.op_a",     64'(cx_op_a_o),  64'd1);
        chk("t2.op_b",     64'(cx_op_b_o),  64'hFFFF_FFFF);
        chk("t2.mode",     64'(cx_mode_o),  64'd1);
        chk("t2.func",     64'(cx_func_o),  64'd0);
        cx_ready_i = 4'b0001;
        tick();
        cx_ready_i = '0;
        chk("t2.wait_cx_valid", 64'(cx_valid_o), 64'd0);
        chk("t2.wait_busy",     64'(busy_o),     64'd1);
        unit_resp(3, 32'hDEAD, 1'b1);
        tick();
        chk("t2.other_ignored", 64'(resp_valid_o), 64'd0);
        chk("t2.still_busy",    64'(busy_o),       64'd1);
        unit_resp(0, 32'hABCD, 1'b1);
        tick();
        clear_unit_inputs();
        check_resp("t2");
        tick();

        // Illegal opcode
        push(32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        send(r_instr(7'h00, 3'd1, 5'd7, 7'h33), 32'd9, 32'd9);
        chk("t3a.cx_valid", 64'(cx_valid_o), 64'd0);
        check_resp("t3a");
        tick();
        chk("t3a.resp_once", 64'(resp_valid_o), 64'd0);

        // Unit id beyond NUM_UNITS
        push(32'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        send(r_instr(7'h01, 3'd5, 5'd8, 7'h0b), 32'd9, 32'd9);
        chk("t3b.cx_valid", 64'(cx_valid_o), 64'd0);
        check_resp("t3b");
        tick();

        // Timeout: unit 1 never ready, CX_FLEX payload
        push(32'd0, 5'd9, 1'b1, 1'b0, 1'b1);
        send(r_instr(7'h2a, 3'd1, 5'd9, 7'h5b), 32'd3, 32'd4);
        chk("t4.mode", 64'(cx_mode_o), 64'd2);
        chk("t4.func", 64'(cx_func_o), 64'h2a);
        chk("t4.op_b", 64'(cx_op_b_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t4.cx_valid_held", 64'(cx_valid_o),   64'h2);
            chk("t4.no_resp_yet",   64'(resp_valid_o), 64'd0);
            tick();
        end
        check_resp("t4");
        chk("t4.cx_valid_drop", 64'(cx_valid_o), 64'd0);
        tick();

        // Response in the final budget cycle beats the timeout
        push(32'h55, 5'd10, 1'b0, 1'b0, 1'b0);
        send(r_instr(7'h00, 3'd3, 5'd10, 7'h0b), 32'd1, 32'd2);
        cx_ready_i = 4'b1000;
        tick();
        cx_ready_i = '0;
        tick();
        tick();
        chk("t4b.last_cycle_busy", 64'(busy_o),       64'd1);
        chk("t4b.last_cycle_resp", 64'(resp_valid_o), 64'd0);
        unit_resp(3, 32'h55, 1'b0);
        tick();
        clear_unit_inputs();
        check_resp("t4b");
        tick();

        // Flush in WAIT, late response ignored, flush blocks accept
        send(r_instr(7'h00, 3'd1, 5'd11, 7'h0b), 32'd1, 32'd1);
        cx_ready_i = 4'b0010;
        tick();
        cx_ready_i = '0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t5.flush_busy", 64'(busy_o),       64'd0);
        chk("t5.flush_resp", 64'(resp_valid_o), 64'd0);
        unit_resp(1, 32'hBAD, 1'b0);
        tick();
        clear_unit_inputs();
        chk("t5.late_resp_ignored", 64'(resp_valid_o), 64'd0);
        chk("t5.late_busy",         64'(busy_o),       64'd0);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_instr_i = r_instr(7'h00, 3'd1, 5'd12, 7'h0b);
        #1;
        chk("t5.ready_during_flush", 64'(req_ready_o), 64'd0);
        tick();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        chk("t5.no_accept_on_flush", 64'(busy_o), 64'd0);
        push(32'd77, 5'd12, 1'b0, 1'b0, 1'b0);
        send(r_instr(7'h00, 3'd1, 5'd12, 7'h0b), 32'd4, 32'd5);
        chk("t5.cx_valid_after", 64'(cx_valid_o), 64'h2);
        cx_ready_i = 4'b0010;
        unit_resp(1, 32'd77, 1'b0);
        tick();
        clear_unit_inputs();
        check_resp("t5");
        tick();

        // Reset pulse during ISSUE
        send(r_instr(7'h00, 3'd2, 5'd13, 7'h0b), 32'd1, 32'd1);
        chk("t6.cx_valid_pre", 64'(cx_valid_o), 64'h4);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6.cx_valid_rst", 64'(cx_valid_o),   64'd0);
        chk("t6.busy_rst",     64'(busy_o),       64'd0);
        chk("t6.resp_rst",     64'(resp_valid_o), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("t6.ready_after", 64'(req_ready_o), 64'd1);
        chk("t6.busy_after",  64'(busy_o),      64'd0);
        tick();
        chk("t6.no_resp", 64'(resp_valid_o), 64'd0);

        chk("sb.drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
